// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM plus an MMIO window holding the LED register,
// a free-running cycle counter and an 8N1 UART transmitter. Loads are combinational.
module data_mem_mmio #(
    parameter int DEPTH        = 256,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_write,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic [7:0]  led_out,
    output logic        uart_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [29:0] A_LED    = 30'h0000_0400;
    localparam logic [29:0] A_CYCLE  = 30'h0000_0401;
    localparam logic [29:0] A_TXDATA = 30'h0000_0402;
    localparam logic [29:0] A_STATUS = 30'h0000_0403;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    logic [31:0]   r_ram [DEPTH];
    logic [7:0]    r_led;
    logic [31:0]   r_cycle;
    logic [7:0]    r_tx_data;
    logic          r_overrun;
    uart_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;

    uart_state_t   w_state_next;
    logic [BW-1:0] w_baud_next;
    logic [2:0]    w_bit_next;
    logic          w_tx_accept;
    logic          w_tx_bit;
    logic [31:0]   w_rd_data;

    // Byte-lane bits are not decoded; only word accesses exist.
    logic          w_unused_ok;
    assign w_unused_ok = &{1'b0, addr[1:0]};

    logic [29:0]   w_word;
    logic [AW-1:0] w_ram_idx;
    logic          w_is_ram;
    logic          w_busy;
    logic          w_baud_done;
    logic          w_wr_led;
    logic          w_wr_cycle;
    logic          w_wr_tx;
    logic          w_wr_status;

    assign w_word      = addr[31:2];
    assign w_ram_idx   = addr[AW+1:2];
    assign w_is_ram    = (addr[31:12] == 20'd0);
    assign w_busy      = (r_state != S_IDLE);
    assign w_baud_done = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_wr_led    = mem_write && (w_word == A_LED);
    assign w_wr_cycle  = mem_write && (w_word == A_CYCLE);
    assign w_wr_tx     = mem_write && (w_word == A_TXDATA);
    assign w_wr_status = mem_write && (w_word == A_STATUS);

    always_ff @(posedge clk) begin
        if (mem_write && w_is_ram && !reset) begin
            r_ram[w_ram_idx] <= mem_write_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_tx_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_tx) begin
                    w_tx_accept  = 1'b1;
                    w_state_next = S_START;
                    w_baud_next  = '0;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_next = S_DATA;
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_state_next = S_IDLE;
                    w_baud_next  = '0;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_tx_data <= 8'd0;
            r_overrun <= 1'b0;
            r_led     <= 8'd0;
            r_cycle   <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
            if (w_tx_accept) begin
                r_tx_data <= mem_write_data[7:0];
            end
            // A dropped write sets overrun even when a clear lands in the same cycle.
            if (w_wr_tx && w_busy) begin
                r_overrun <= 1'b1;
            end else if (w_wr_status && mem_write_data[1]) begin
                r_overrun <= 1'b0;
            end
            if (w_wr_led) begin
                r_led <= mem_write_data[7:0];
            end
            r_cycle <= w_wr_cycle ? mem_write_data : r_cycle + 32'd1;
        end
    end

    always_comb begin
        w_tx_bit = 1'b1;
        case (r_state)
            S_START: w_tx_bit = 1'b0;
            S_DATA:  w_tx_bit = r_tx_data[r_bit_idx];
            default: w_tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        w_rd_data = 32'd0;
        if (w_is_ram) begin
            w_rd_data = r_ram[w_ram_idx];
        end else begin
            case (w_word)
                A_LED:    w_rd_data = {24'd0, r_led};
                A_CYCLE:  w_rd_data = r_cycle;
                A_TXDATA: w_rd_data = {24'd0, r_tx_data};
                A_STATUS: w_rd_data = {30'd0, r_overrun, w_busy};
                default:  w_rd_data = 32'd0;
            endcase
        end
    end

    assign mem_read_data = w_rd_data;
    assign led_out       = r_led;
    assign uart_tx       = w_tx_bit;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, LED, CYCLE and UART/overrun behaviour
// with CLKS_PER_BIT=4, checked by immediate assertions.
module tb_data_mem_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [7:0]  led_out;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;

    logic [31:0] v1;
    logic [31:0] v2;

    data_mem_mmio #(
        .DEPTH(256),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .mem_write(mem_write),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .led_out(led_out),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr           = a;
        mem_write_data = d;
        mem_write      = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr      = a;
        mem_write = 1'b0;
        #1;
        chk(mem_read_data, exp, tag);
    endtask

    // Samples each of the ten bit cells mid-cell; caller positions the first sample.
    task automatic check_frame(input logic [7:0] b, input int first_wait, input string tag);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        repeat (first_wait) @(posedge clk);
        #1;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) begin
                repeat (4) @(posedge clk);
                #1;
            end
            chk({31'd0, uart_tx}, {31'd0, f[j]}, $sformatf("%s_bit%0d", tag, j));
        end
    endtask

    initial begin
        reset          = 1'b1;
        addr           = 32'd0;
        mem_write      = 1'b0;
        mem_write_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk({24'd0, led_out}, 32'd0, "rst_led_out");
        chk({31'd0, uart_tx}, 32'd1, "rst_uart_tx");
        rd_chk(32'h1000, 32'd0, "rst_led_rd");
        rd_chk(32'h100C, 32'd0, "rst_status");
        rd_chk(32'h1008, 32'd0, "rst_txdata");

        // Cycle counter free-runs
        @(posedge clk);
        #1;
        addr = 32'h1004;
        #1;
        v1 = mem_read_data;
        repeat (2) @(posedge clk);
        #2;
        v2 = mem_read_data;
        chk(v2 - v1, 32'd2, "cycle_delta");

        // RAM
        wr(32'h0010, 32'hDEADBEEF);
        wr(32'h0014, 32'hCAFEF00D);
        rd_chk(32'h0010, 32'hDEADBEEF, "ram_10");
        rd_chk(32'h0014, 32'hCAFEF00D, "ram_14");
        @(negedge clk);
        addr           = 32'h0010;
        mem_write_data = 32'h11111111;
        mem_write      = 1'b1;
        #1;
        chk(mem_read_data, 32'hDEADBEEF, "ram_same_cycle_old");
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        #1;
        chk(mem_read_data, 32'h11111111, "ram_next_cycle_new");
        rd_chk(32'h0013, 32'h11111111, "ram_low_bits_ignored");
        wr(32'h0400, 32'h12345678);
        rd_chk(32'h0000, 32'h12345678, "ram_alias");
        rd_chk(32'h2000, 32'd0, "unmapped_2000");
        rd_chk(32'h1010, 32'd0, "unmapped_1010");
        wr(32'h2000, 32'hFFFFFFFF);
        rd_chk(32'h0000, 32'h12345678, "unmapped_write_ignored");

        // LED
        wr(32'h1000, 32'h123456AB);
        chk({24'd0, led_out}, 32'h000000AB, "led_out");
        rd_chk(32'h1000, 32'h000000AB, "led_rd");

        // CYCLE load and wrap
        wr(32'h1004, 32'hFFFFFFFE);
        rd_chk(32'h1004, 32'hFFFFFFFE, "cycle_load");
        @(posedge clk);
        #1;
        chk(mem_read_data, 32'hFFFFFFFF, "cycle_max");
        @(posedge clk);
        #1;
        chk(mem_read_data, 32'h00000000, "cycle_wrap");

        // UART frame 0xA5 and busy timing
        wr(32'h1008, 32'h000000A5);
        rd_chk(32'h100C, 32'd1, "a5_busy_start");
        check_frame(8'hA5, 2, "a5");
        rd_chk(32'h100C, 32'd1, "a5_busy_38");
        @(posedge clk);
        #1;
        rd_chk(32'h100C, 32'd1, "a5_busy_39");
        @(posedge clk);
        #1;
        rd_chk(32'h100C, 32'd0, "a5_idle_40");
        chk({31'd0, uart_tx}, 32'd1, "a5_idle_line");
        rd_chk(32'h1008, 32'h000000A5, "a5_txdata");

        // Overrun
        wr(32'h1008, 32'h00000041);
        wr(32'h1008, 32'h00000042);
        rd_chk(32'h1008, 32'h00000041, "ovr_txdata");
        rd_chk(32'h100C, 32'd3, "ovr_status_set");
        wr(32'h100C, 32'h00000002);
        rd_chk(32'h100C, 32'd1, "ovr_status_cleared");
        check_frame(8'h41, 0, "ovr");
        repeat (2) @(posedge clk);
        #1;
        rd_chk(32'h100C, 32'd0, "ovr_idle");

        // Reset mid-frame during data bit 3
        wr(32'h1008, 32'h00000052);
        repeat (17) @(posedge clk);
        #1;
        chk({31'd0, uart_tx}, 32'd0, "mid_bit3");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk({31'd0, uart_tx}, 32'd1, "mid_rst_uart_tx");
        rd_chk(32'h100C, 32'd0, "mid_rst_status");
        rd_chk(32'h1008, 32'd0, "mid_rst_txdata");
        rd_chk(32'h1004, 32'd0, "mid_rst_cycle");
        chk({24'd0, led_out}, 32'd0, "mid_rst_led");
        @(negedge clk);
        reset = 1'b0;
        wr(32'h1008, 32'h0000003C);
        check_frame(8'h3C, 2, "post_rst");
        repeat (2) @(posedge clk);
        #1;
        rd_chk(32'h100C, 32'd0, "post_rst_idle");
        rd_chk(32'h1008, 32'h0000003C, "post_rst_txdata");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
